// File: rtl/trace_pkg.sv
// Shared types for the retire trace buffer: the 134-bit trace record and the capture state encoding.
package trace_pkg;

    localparam int TRACE_ENTRY_W = 134;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        wb_valid;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        TRIGGERED = 2'd2,
        FROZEN    = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular first-word-fall-through FIFO of trace records with synchronous flush.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  trace_entry_t             wr_entry,
    output logic                     rd_valid,
    output trace_entry_t             rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_valid = (count != '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: stamps retired instructions into a FIFO with a PC-match trigger that freezes
// capture POST_TRIGGER records after the event. Define TRACE_LOG_EN for sim-only JSON logging.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int POST_TRIGGER = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   retire_valid_i,
    input  logic [31:0]            retire_pc_i,
    input  logic [31:0]            retire_ir_i,
    input  logic                   retire_wb_valid_i,
    input  logic [4:0]             retire_wb_addr_i,
    input  logic [31:0]            retire_wb_data_i,
    input  logic                   trace_enable_i,
    input  logic                   trace_clear_i,
    input  logic                   trigger_en_i,
    input  logic [31:0]            trigger_pc_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output trace_entry_t           rd_entry_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [15:0]            dropped_o,
    output logic [1:0]             state_o
);

    // Read port handshake: a record transfers on any cycle with rd_valid_o && rd_ready_i;
    // rd_valid_o never depends on rd_ready_i, and rd_entry_o is stable while rd_valid_o is high.

    trace_state_t state, state_next;
    logic [31:0]  stamp;
    logic [15:0]  post_cnt, post_next;
    logic         full, accept, push, pop, drop, hit;
    trace_entry_t new_entry;

    assign pop    = rd_valid_o & rd_ready_i;
    assign accept = retire_valid_i & ((state == CAPTURE) || (state == TRIGGERED));
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;
    assign hit    = trigger_en_i & push & (retire_pc_i == trigger_pc_i);

    assign new_entry = '{cycle: stamp, pc: retire_pc_i, ir: retire_ir_i, wb_valid: retire_wb_valid_i,
                         wb_addr: retire_wb_addr_i, wb_data: retire_wb_data_i};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush     (trace_clear_i),
        .push      (push),
        .pop       (pop),
        .wr_entry  (new_entry),
        .rd_valid  (rd_valid_o),
        .rd_entry  (rd_entry_o),
        .count     (count_o),
        .full      (full)
    );

    always_comb begin
        state_next = state;
        post_next  = post_cnt;
        unique case (state)
            IDLE: if (trace_enable_i) state_next = CAPTURE;
            CAPTURE: begin
                if (!trace_enable_i) begin
                    state_next = IDLE;
                end else if (hit) begin
                    post_next  = 16'd1;
                    state_next = (POST_TRIGGER == 1) ? FROZEN : TRIGGERED;
                end
            end
            TRIGGERED: begin
                if (!trace_enable_i) begin
                    state_next = IDLE;
                end else if (push) begin
                    post_next = post_cnt + 16'd1;
                    if (post_next == 16'(POST_TRIGGER)) state_next = FROZEN;
                end
            end
            FROZEN:  state_next = FROZEN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || trace_clear_i) begin
            state    <= IDLE;
            post_cnt <= '0;
        end else begin
            state    <= state_next;
            post_cnt <= post_next;
        end
    end

    // The stamp survives a clear so records stay comparable against the CPU's own cycle count.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) stamp <= '0;
        else            stamp <= stamp + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || trace_clear_i) begin
            overflow_o <= 1'b0;
            dropped_o  <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
        end
    end

    assign state_o = state;

`ifdef TRACE_LOG_EN
`ifndef LOG_DISPLAY
`define LOG_DISPLAY $display
`endif
    always_ff @(posedge clk_i) begin
        if (reset_n_i && !trace_clear_i) begin
            if (push)
                `LOG_DISPLAY("{\"cycle\":%0d,\"pc\":%0d,\"ir\":%0d,\"rd\":%0d,\"wb\":%0d}",
                             stamp, retire_pc_i, retire_ir_i, retire_wb_addr_i, retire_wb_data_i);
            if (drop)
                `LOG_DISPLAY("{\"drop\":%0d}", stamp);
        end
    end
`endif

endmodule
